// File: rtl/rca_pkg.sv
// Shared definitions for the multi-limb ripple-carry add controller.
//   rca_seq_state_t : controller FSM states
//   DWIDTH_DEF      : default limb width (width of the attached RCA)
//   NLIMBS_DEF      : default number of limbs per wide operand
//   limb_cw()       : width of a counter that indexes NLIMBS limbs (minimum 1 bit)
package rca_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } rca_seq_state_t;

    localparam int DWIDTH_DEF = 32;
    localparam int NLIMBS_DEF = 4;

    // A single-limb configuration still needs a 1-bit counter so the
    // declarations stay legal.
    function automatic int limb_cw(input int nlimbs);
        if (nlimbs <= 1) begin
            return 1;
        end else begin
            return $clog2(nlimbs);
        end
    endfunction

endpackage

// File: rtl/rca_seq_ctrl.sv
// Multi-limb add controller wrapped around an external DWIDTH-bit ripple-carry
// adder. A wide W = DWIDTH*NLIMBS request is accepted over valid/ready, the
// operands are fed to the RCA one limb per cycle (LSB limb first, carry
// chained through carry_r), and the result is held until the consumer takes it.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          request handshake
//   in_a, in_b, in_cin         wide operands and carry into limb 0
//   rca_a, rca_b, rca_cin      current limb presented to the external RCA
//   rca_res, rca_cout          combinational RCA result for that limb
//   out_valid/out_ready        result handshake
//   out_sum, out_cout, out_ovf wide sum, carry out of MSB limb, signed overflow
module rca_seq_ctrl
    import rca_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int NLIMBS = NLIMBS_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DWIDTH*NLIMBS-1:0]   in_a,
    input  logic [DWIDTH*NLIMBS-1:0]   in_b,
    input  logic                       in_cin,
    output logic [DWIDTH-1:0]          rca_a,
    output logic [DWIDTH-1:0]          rca_b,
    output logic                       rca_cin,
    input  logic [DWIDTH-1:0]          rca_res,
    input  logic                       rca_cout,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DWIDTH*NLIMBS-1:0]   out_sum,
    output logic                       out_cout,
    output logic                       out_ovf
);

    localparam int W       = DWIDTH * NLIMBS;
    localparam int LIMB_CW = limb_cw(NLIMBS);
    localparam logic [LIMB_CW-1:0] LAST_LIMB = LIMB_CW'(NLIMBS - 1);

    rca_seq_state_t      state_r;
    rca_seq_state_t      state_next_s;
    logic [LIMB_CW-1:0]  limb_cnt_r;
    logic [W-1:0]        a_r;
    logic [W-1:0]        b_r;
    logic [W-1:0]        sum_r;
    logic                carry_r;
    logic                ovf_r;
    logic                accept_s;
    logic                last_limb_s;
    int                  limb_lo_s;

    assign last_limb_s = (limb_cnt_r == LAST_LIMB);
    assign limb_lo_s   = int'(limb_cnt_r) * DWIDTH;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; accept_s marks the edge on which a request is latched.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    accept_s     = 1'b1;
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (last_limb_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    // Result consumed; a waiting request chains straight into RUN.
                    if (in_valid) begin
                        accept_s     = 1'b1;
                        state_next_s = RUN;
                    end else begin
                        state_next_s = IDLE;
                    end
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Operand capture, per-limb sum write-back and carry chaining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r        <= {W{1'b0}};
            b_r        <= {W{1'b0}};
            sum_r      <= {W{1'b0}};
            carry_r    <= 1'b0;
            ovf_r      <= 1'b0;
            limb_cnt_r <= {LIMB_CW{1'b0}};
        end else if (accept_s) begin
            a_r        <= in_a;
            b_r        <= in_b;
            carry_r    <= in_cin;
            ovf_r      <= 1'b0;
            limb_cnt_r <= {LIMB_CW{1'b0}};
        end else if (state_r == RUN) begin
            sum_r[limb_lo_s +: DWIDTH] <= rca_res;
            carry_r                    <= rca_cout;
            if (last_limb_s) begin
                limb_cnt_r <= {LIMB_CW{1'b0}};
                // Final limb carries the sign bit of the wide result.
                ovf_r      <= (a_r[W-1] == b_r[W-1]) && (rca_res[DWIDTH-1] != a_r[W-1]);
            end else begin
                limb_cnt_r <= limb_cnt_r + LIMB_CW'(1);
                ovf_r      <= ovf_r;
            end
        end else begin
            limb_cnt_r <= limb_cnt_r;
        end
    end

    // Limb mux towards the RCA; held at zero outside RUN so the adder stays quiet.
    always_comb begin
        rca_a   = {DWIDTH{1'b0}};
        rca_b   = {DWIDTH{1'b0}};
        rca_cin = 1'b0;
        if (state_r == RUN) begin
            rca_a   = a_r[limb_lo_s +: DWIDTH];
            rca_b   = b_r[limb_lo_s +: DWIDTH];
            rca_cin = carry_r;
        end else begin
            rca_a   = {DWIDTH{1'b0}};
            rca_b   = {DWIDTH{1'b0}};
            rca_cin = 1'b0;
        end
    end

    // in_ready is forced low while reset is asserted.
    assign in_ready  = rst_n && ((state_r == IDLE) || ((state_r == DONE) && out_ready));
    assign out_valid = (state_r == DONE);
    assign out_sum   = sum_r;
    assign out_cout  = carry_r;
    assign out_ovf   = ovf_r;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Directed self-checking bench for rca_seq_ctrl (DWIDTH=32, NLIMBS=4).
// A behavioural 32-bit adder stands in for the external RCA.
module tb_rca_seq_ctrl;

    localparam int DW = 32;
    localparam int NL = 4;
    localparam int W  = DW * NL;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_a;
    logic [W-1:0]   in_b;
    logic           in_cin;
    logic [DW-1:0]  rca_a;
    logic [DW-1:0]  rca_b;
    logic           rca_cin;
    logic [DW-1:0]  rca_res;
    logic           rca_cout;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_sum;
    logic           out_cout;
    logic           out_ovf;
    logic [DW:0]    rca_full;

    int total;
    int bad;

    rca_seq_ctrl #(.DWIDTH(DW), .NLIMBS(NL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .rca_a     (rca_a),
        .rca_b     (rca_b),
        .rca_cin   (rca_cin),
        .rca_res   (rca_res),
        .rca_cout  (rca_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    // External narrow adder.
    assign rca_full = {1'b0, rca_a} + {1'b0, rca_b} + {{DW{1'b0}}, rca_cin};
    assign rca_res  = rca_full[DW-1:0];
    assign rca_cout = rca_full[DW];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request and step through its accept edge (bounded).
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                            output logic ok);
        int n;
        in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        ok = in_ready;
        tick();
        in_valid = 1'b0;
        in_a = {W{1'b0}}; in_b = {W{1'b0}}; in_cin = 1'b0;
    endtask

    // Count edges until out_valid rises (bounded).
    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 20) begin
            tick();
            cycles++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        rst_n = 1'b0;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%0b want=0", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
        total++; if ({out_sum, out_cout, out_ovf} !== {W+2{1'b0}}) begin bad++; $display("FAIL reset_outputs got=%h want=0", {out_sum, out_cout, out_ovf}); end
        total++; if ({rca_a, rca_b, rca_cin} !== {2*DW+1{1'b0}}) begin bad++; $display("FAIL reset_rca got=%h want=0", {rca_a, rca_b, rca_cin}); end
        tick();
        rst_n = 1'b1;
        tick();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready got=%0b want=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL release_out_valid got=%0b want=0", out_valid); end
    endtask

    task automatic test_ripple();
        logic       ok;
        logic [3:0] exp_cin;
        int         cyc;
        exp_cin = 4'b1110;
        start_op(128'h0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'h1, 1'b0, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL ripple_accept timeout"); end
        for (int i = 0; i < NL; i++) begin
            total++; if (rca_cin !== exp_cin[i]) begin bad++; $display("FAIL ripple_cin limb=%0d got=%0b want=%0b", i, rca_cin, exp_cin[i]); end
            total++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL ripple_run limb=%0d in_ready=%0b out_valid=%0b want 0/0", i, in_ready, out_valid); end
            tick();
        end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ripple_latency out_valid=%0b want=1 after 4 edges", out_valid); end
        wait_valid(cyc);
        total++; if (out_sum !== 128'h0000_0001_0000_0000_0000_0000_0000_0000) begin bad++; $display("FAIL ripple_sum got=%h want=%h", out_sum, 128'h0000_0001_0000_0000_0000_0000_0000_0000); end
        total++; if (out_cout !== 1'b0 || out_ovf !== 1'b0) begin bad++; $display("FAIL ripple_flags cout=%0b ovf=%0b want 0/0", out_cout, out_ovf); end
        total++; if (rca_a !== {DW{1'b0}} || rca_cin !== 1'b0) begin bad++; $display("FAIL ripple_rca_quiet rca_a=%h rca_cin=%0b want 0", rca_a, rca_cin); end
        consume();
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL ripple_consume out_valid=%0b in_ready=%0b want 0/1", out_valid, in_ready); end
    endtask

    task automatic test_wrap();
        logic ok;
        int   cyc;
        start_op({W{1'b1}}, {W{1'b0}}, 1'b1, ok);
        wait_valid(cyc);
        total++; if (cyc !== 4) begin bad++; $display("FAIL wrap_latency got=%0d want=4", cyc); end
        total++; if (out_sum !== {W{1'b0}}) begin bad++; $display("FAIL wrap_sum got=%h want=0", out_sum); end
        total++; if (out_cout !== 1'b1 || out_ovf !== 1'b0) begin bad++; $display("FAIL wrap_flags cout=%0b ovf=%0b want 1/0", out_cout, out_ovf); end
        consume();
    endtask

    task automatic test_overflow();
        logic ok;
        int   cyc;
        start_op({1'b0, {W-1{1'b1}}}, 128'h1, 1'b0, ok);
        // Junk request while busy must be ignored.
        in_valid = 1'b1; in_a = 128'h1234; in_b = 128'h5678; in_cin = 1'b1;
        wait_valid(cyc);
        in_valid = 1'b0; in_a = {W{1'b0}}; in_b = {W{1'b0}}; in_cin = 1'b0;
        total++; if (cyc !== 4) begin bad++; $display("FAIL ovf_latency got=%0d want=4", cyc); end
        total++; if (out_sum !== {1'b1, {W-1{1'b0}}}) begin bad++; $display("FAIL ovf_sum got=%h want=%h", out_sum, {1'b1, {W-1{1'b0}}}); end
        total++; if (out_cout !== 1'b0 || out_ovf !== 1'b1) begin bad++; $display("FAIL ovf_flags cout=%0b ovf=%0b want 0/1", out_cout, out_ovf); end
        consume();
    endtask

    task automatic test_back_to_back();
        logic ok;
        int   cyc;
        start_op(128'h3, 128'h4, 1'b0, ok);
        wait_valid(cyc);
        for (int i = 0; i < 5; i++) begin
            total++; if (out_valid !== 1'b1 || out_sum !== 128'h7 || in_ready !== 1'b0) begin bad++; $display("FAIL bp_hold cyc=%0d valid=%0b sum=%h in_ready=%0b want 1/7/0", i, out_valid, out_sum, in_ready); end
            tick();
        end
        in_a = 128'd100; in_b = 128'd23; in_cin = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready got=%0b want=1", in_ready); end
        tick();
        in_valid = 1'b0; out_ready = 1'b0; in_a = {W{1'b0}}; in_b = {W{1'b0}}; in_cin = 1'b0;
        total++; if (out_valid !== 1'b0 || rca_a !== 32'd100) begin bad++; $display("FAIL bp_chain valid=%0b rca_a=%h want 0/64", out_valid, rca_a); end
        wait_valid(cyc);
        total++; if (cyc !== 4) begin bad++; $display("FAIL bp_latency got=%0d want=4", cyc); end
        total++; if (out_sum !== 128'd124 || out_cout !== 1'b0) begin bad++; $display("FAIL bp_sum got=%h cout=%0b want=7c/0", out_sum, out_cout); end
        consume();
    endtask

    task automatic test_abort();
        logic ok;
        int   cyc;
        int   seen;
        start_op({W{1'b1}}, 128'h1, 1'b0, ok);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || rca_a !== {DW{1'b0}}) begin bad++; $display("FAIL abort_reset valid=%0b rca_a=%h want 0/0", out_valid, rca_a); end
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL abort_no_valid got=%0d want=0", seen); end
        // out_ready with nothing pending is harmless.
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL idle_out_ready valid=%0b in_ready=%0b want 0/1", out_valid, in_ready); end
        start_op(128'd5, 128'd7, 1'b0, ok);
        wait_valid(cyc);
        total++; if (cyc !== 4) begin bad++; $display("FAIL abort_next_latency got=%0d want=4", cyc); end
        total++; if (out_sum !== 128'd12 || out_cout !== 1'b0 || out_ovf !== 1'b0) begin bad++; $display("FAIL abort_next_sum got=%h cout=%0b ovf=%0b want=c/0/0", out_sum, out_cout, out_ovf); end
        consume();
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = {W{1'b0}};
        in_b      = {W{1'b0}};
        in_cin    = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        test_reset();
        test_ripple();
        test_wrap();
        test_overflow();
        test_back_to_back();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
